display_mmio_regs: RTL and testbench
====================================

Name: display_mmio_regs

Overview:
- Memory-mapped peripheral that lets the RISC-V core drive the 8-digit seven-segment display.
- Sits on the data-memory bus, decoded by address.
- Holds the 32-bit value fed to the display controller's data_to_display input.
- Also produces a per-digit blank mask, which top level uses to force segments off for blinking or blanking.
- Adds a freeze shadow register, a blink prescaler and a DATA write counter.

Parameters:
- BASE_ADDR, 32'h8000_0000, base of the 16-byte register window; must be 16-byte aligned.
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (1 Hz blink at 50 MHz); must be ≥ 2.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- addr  input  32  bus byte address
- we  input  1  bus write strobe (store instruction)
- wbe  input  4  byte enables for wdata; bit i covers wdata[8i+7:8i]
- wdata  input  32  bus write data
- rdata  output  32  read data, combinational from addr
- data_to_display  output  32  value fed to the display controller
- blank_mask  output  8  bit i=1 forces digit i (hexi) off; top level does the gating

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Decode:
  - sel = (addr[31:4] == BASE_ADDR[31:4]).
  - Register offset = addr[3:2]. addr[1:0] is ignored.
  - A write occurs only when sel & we; bytes are written per wbe.
- Register map:
  - 0x0 DATA: RW, all 32 bits.
  - 0x4 CTRL: RW.
    - bit0 blink_en
    - bit1 blank_force
    - bit2 freeze
    - bits[15:8] digit_mask
    - other bits reserved: read 0, writes dropped.
  - 0x8 STATUS: RO, writes ignored.
    - bit0 blink_phase
    - bits[31:16] wr_count
    - others 0.
  - 0xC: reads 0, writes ignored.
- Read path: rdata = register at offset when sel=1, else 32'h0. No read side effects.
- Reset values: DATA, CTRL, shadow, prescaler, blink_phase and wr_count all reset to 0, so data_to_display=0, blank_mask=0, rdata=0 (for any addr).
- Register update: registers update on the rising edge where the write is presented. A write is visible on rdata in the next cycle.
- Shadow (data_to_display):
  - Registered. Loads the current DATA register on every edge where CTRL.freeze=0; holds while freeze=1.
  - DATA write to data_to_display latency is 2 edges: DATA at edge N, output at edge N+1.
  - Same-edge write of DATA and CTRL.freeze=1: freeze is still 0 at that edge, so the shadow captures the OLD DATA. The new DATA stays hidden until freeze clears.
  - Clearing freeze: the shadow picks up the current DATA at the next edge.
- Blink prescaler (counts 0..BLINK_DIV-1):
  - Runs only while CTRL.blink_en=1. At count BLINK_DIV-1 it wraps to 0 and toggles blink_phase.
  - While blink_en=0, the counter and blink_phase are held at 0.
  - Clearing blink_en on the same edge as terminal count: clear wins, so counter=0 and phase=0.
  - Setting blink_en: counting starts from 0, and the first toggle occurs BLINK_DIV edges after the enable edge.
- blank_mask: registered version of digit_mask & ({8{blank_force}} | {8{blink_en & blink_phase}}), computed from current register state, so 1-cycle latency.
- wr_count:
  - Increments by 1 on each decoded DATA write with wbe≠0.
  - Wraps 0xFFFF to 0x0000.
  - Writes with wbe=0 do not count.
- Reset mid-operation: all state clears immediately (asynchronous), outputs go to reset values, and the blink count restarts from 0 after release.

Test Plan (bench uses BLINK_DIV=4):
- Reset, then write DATA=32'h12345678 with wbe=4'hF → after 2 edges data_to_display=32'h12345678; STATUS read=32'h0001_0000.
- Write CTRL=32'h0000_0004 (freeze), then DATA=32'hDEADBEEF → data_to_display holds 32'h12345678 and DATA reads back 32'hDEADBEEF. Write CTRL=0 → data_to_display=32'hDEADBEEF one edge later.
- Write CTRL=32'h0000_0F01 (blink on digits 0-3) → blank_mask alternates 8'h00/8'h0F every 4 cycles and STATUS bit0 tracks it. Clear CTRL on a terminal-count edge → blank_mask=8'h00 and phase=0.
- Partial write: DATA=32'hFFFFFFFF, then write wdata=32'h0000AB00 with wbe=4'b0010 → DATA=32'hFFFFABFF; wbe=0 write leaves DATA and wr_count unchanged. CTRL write of 32'hFFFFFFFF reads back 32'h0000FF07.
- Address decode: write to BASE_ADDR+0x10 and to 0xC → no register changes. Read of offset 0xC and of a non-matching addr → rdata=0.
- Counter wrap and reset: 65536 DATA writes → wr_count=0. Assert rst_n low mid-blink with freeze set → all outputs are 0 immediately, and CTRL reads 0 after release.

Source files
------------

// File: rtl/display_mmio_regs.sv
// Memory-mapped register block for the 8-digit seven-segment display.
// Provides DATA/CTRL/STATUS registers, a freezable display shadow,
// a blink prescaler and a 16-bit DATA write counter.
module display_mmio_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  wbe,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] data_to_display,
    output logic [7:0]  blank_mask
);

    localparam int unsigned CNT_W = (BLINK_DIV >= 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_CTRL   = 2'd1,
        REG_STATUS = 2'd2,
        REG_RSVD   = 2'd3
    } reg_off_t;

    logic [31:0]      data_reg;
    logic             blink_en;
    logic             blank_force;
    logic             freeze;
    logic [7:0]       digit_mask;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;
    logic [15:0]      wr_count;

    logic             sel;
    reg_off_t         off;
    logic             wr_data;
    logic             wr_ctrl;
    logic             blink_en_next;
    logic             blink_run;
    logic [31:0]      ctrl_word;
    logic [31:0]      status_word;
    logic             unused_addr_bits;

    assign sel     = (addr[31:4] == BASE_ADDR[31:4]);
    assign off     = reg_off_t'(addr[3:2]);
    assign wr_data = sel & we & (off == REG_DATA);
    assign wr_ctrl = sel & we & (off == REG_CTRL);

    assign unused_addr_bits = ^addr[1:0];

    // The prescaler only advances when blink_en is set both before and after
    // this edge: a same-edge clear beats the terminal-count toggle, and a
    // fresh enable spends its first edge at count 0.
    assign blink_en_next = (wr_ctrl & wbe[0]) ? wdata[0] : blink_en;
    assign blink_run     = blink_en & blink_en_next;

    assign ctrl_word   = {16'h0000, digit_mask, 5'b00000, freeze, blank_force, blink_en};
    assign status_word = {wr_count, 15'h0000, blink_phase};

    // DATA register with byte enables and the DATA write counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            wr_count <= '0;
        end else if (wr_data) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wbe[i]) begin
                    data_reg[8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (wbe != '0) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    // CTRL register fields; reserved bits are simply not stored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_en    <= 1'b0;
            blank_force <= 1'b0;
            freeze      <= 1'b0;
            digit_mask  <= '0;
        end else if (wr_ctrl) begin
            if (wbe[0]) begin
                blink_en    <= wdata[0];
                blank_force <= wdata[1];
                freeze      <= wdata[2];
            end
            if (wbe[1]) begin
                digit_mask <= wdata[15:8];
            end
        end
    end

    // Display shadow follows DATA one edge late unless frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_to_display <= '0;
        end else if (!freeze) begin
            data_to_display <= data_reg;
        end
    end

    // Blink prescaler and phase toggle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!blink_run) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
        end
    end

    // Registered per-digit blank mask from current register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_mask <= '0;
        end else begin
            blank_mask <= digit_mask & ({8{blank_force}} | {8{blink_en & blink_phase}});
        end
    end

    // Combinational read mux
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                REG_DATA:   rdata = data_reg;
                REG_CTRL:   rdata = ctrl_word;
                REG_STATUS: rdata = status_word;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_display_mmio_regs.sv
// Self-checking bench for display_mmio_regs: directed vector table,
// hand-written blink/reset/wrap sequences and a randomized run against
// a behavioural model of the register block.
module tb_display_mmio_regs;

    localparam logic [31:0] B   = 32'h8000_0000;
    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] data_to_display;
    logic [7:0]  blank_mask;

    int unsigned checks = 0;
    int unsigned errors = 0;

    display_mmio_regs #(
        .BASE_ADDR(B),
        .BLINK_DIV(DIV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .addr(addr),
        .we(we),
        .wbe(wbe),
        .wdata(wdata),
        .rdata(rdata),
        .data_to_display(data_to_display),
        .blank_mask(blank_mask)
    );

    always #5 clk = ~clk;

    // Behavioural model: the blink phase is derived from how many edges
    // have elapsed with blinking continuously enabled.
    logic [31:0] m_data, m_ctrl, m_shadow;
    logic [15:0] m_wrcnt;
    logic [7:0]  m_mask;
    int unsigned m_en_edges;

    function automatic logic m_phase();
        return ((m_en_edges / DIV) % 2) == 1;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:4] != B[31:4]) return 32'h0;
        case (a[3:2])
            2'd0:    return m_data;
            2'd1:    return m_ctrl;
            2'd2:    return {m_wrcnt, 15'h0, m_phase()};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_data = '0; m_ctrl = '0; m_shadow = '0;
        m_wrcnt = '0; m_mask = '0; m_en_edges = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock edge with the given bus request; model advances alongside.
    task automatic cycle(input logic [31:0] a, input logic w, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] n_data, n_ctrl, n_shadow;
        logic [15:0] n_wrcnt;
        logic [7:0]  n_mask;
        int unsigned n_en;
        logic        hit;
        addr = a; we = w; wbe = be; wdata = d;
        hit      = w && (a[31:4] == B[31:4]);
        n_data   = m_data;
        n_ctrl   = m_ctrl;
        n_wrcnt  = m_wrcnt;
        for (int i = 0; i < 4; i++) begin
            if (hit && be[i] && a[3:2] == 2'd0) n_data[8*i +: 8] = d[8*i +: 8];
            if (hit && be[i] && a[3:2] == 2'd1) n_ctrl[8*i +: 8] = d[8*i +: 8];
        end
        n_ctrl = n_ctrl & 32'h0000_FF07;
        if (hit && a[3:2] == 2'd0 && be != 4'h0) n_wrcnt = m_wrcnt + 16'd1;
        n_shadow = m_ctrl[2] ? m_shadow : m_data;
        n_mask   = '0;
        for (int i = 0; i < 8; i++) begin
            if (m_ctrl[8+i] && (m_ctrl[1] || (m_ctrl[0] && m_phase()))) n_mask[i] = 1'b1;
        end
        n_en = (m_ctrl[0] && n_ctrl[0]) ? m_en_edges + 1 : 0;
        @(posedge clk);
        #1;
        m_data = n_data; m_ctrl = n_ctrl; m_shadow = n_shadow;
        m_wrcnt = n_wrcnt; m_mask = n_mask; m_en_edges = n_en;
        we = 1'b0;
    endtask

    task automatic idle();
        cycle(B, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a; we = 1'b0; wbe = 4'h0; wdata = 32'h0;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; addr = '0; we = 1'b0; wbe = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wbe;
        logic [31:0] wdata;
        logic [31:0] rd_addr;
        logic [31:0] exp_rd;
        logic [31:0] exp_disp;
        logic [7:0]  exp_mask;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [3:0] be,
                                input logic [31:0] d, input logic [31:0] ra, input logic [31:0] er,
                                input logic [31:0] ed, input logic [7:0] em);
        vec_t v;
        v.addr = a; v.we = w; v.wbe = be; v.wdata = d;
        v.rd_addr = ra; v.exp_rd = er; v.exp_disp = ed; v.exp_mask = em;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(B,        1, 4'hF, 32'h1234_5678, B,        32'h1234_5678, 32'h0000_0000, 8'h00);
        vecs[1]  = mk(B,        0, 4'h0, 32'h0,         B+8,      32'h0001_0000, 32'h1234_5678, 8'h00);
        vecs[2]  = mk(B+4,      1, 4'hF, 32'h0000_0004, B+4,      32'h0000_0004, 32'h1234_5678, 8'h00);
        vecs[3]  = mk(B,        1, 4'hF, 32'hDEAD_BEEF, B,        32'hDEAD_BEEF, 32'h1234_5678, 8'h00);
        vecs[4]  = mk(B,        0, 4'h0, 32'h0,         B+8,      32'h0002_0000, 32'h1234_5678, 8'h00);
        vecs[5]  = mk(B+4,      1, 4'hF, 32'h0,         B+4,      32'h0000_0000, 32'h1234_5678, 8'h00);
        vecs[6]  = mk(B,        0, 4'h0, 32'h0,         B,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 8'h00);
        vecs[7]  = mk(B,        1, 4'hF, 32'hFFFF_FFFF, B,        32'hFFFF_FFFF, 32'hDEAD_BEEF, 8'h00);
        vecs[8]  = mk(B,        1, 4'h2, 32'h0000_AB00, B,        32'hFFFF_ABFF, 32'hFFFF_FFFF, 8'h00);
        vecs[9]  = mk(B,        1, 4'h0, 32'h0,         B+8,      32'h0004_0000, 32'hFFFF_ABFF, 8'h00);
        vecs[10] = mk(B,        0, 4'h0, 32'h0,         B,        32'hFFFF_ABFF, 32'hFFFF_ABFF, 8'h00);
        vecs[11] = mk(B+4,      1, 4'hF, 32'hFFFF_FFFF, B+4,      32'h0000_FF07, 32'hFFFF_ABFF, 8'h00);
        vecs[12] = mk(B+4,      1, 4'hF, 32'h0,         B+4,      32'h0000_0000, 32'hFFFF_ABFF, 8'hFF);
        vecs[13] = mk(B,        0, 4'h0, 32'h0,         B+8,      32'h0004_0000, 32'hFFFF_ABFF, 8'h00);
        vecs[14] = mk(B+32'h10, 1, 4'hF, 32'h1111_1111, B,        32'hFFFF_ABFF, 32'hFFFF_ABFF, 8'h00);
        vecs[15] = mk(B+32'hC,  1, 4'hF, 32'h2222_2222, B+32'hC,  32'h0000_0000, 32'hFFFF_ABFF, 8'h00);
        vecs[16] = mk(B,        0, 4'h0, 32'h0,         32'h0,    32'h0000_0000, 32'hFFFF_ABFF, 8'h00);
        vecs[17] = mk(B,        0, 4'h0, 32'h0,         B+32'h10, 32'h0000_0000, 32'hFFFF_ABFF, 8'h00);
        vecs[18] = mk(B,        0, 4'h0, 32'h0,         B+8,      32'h0004_0000, 32'hFFFF_ABFF, 8'h00);
        vecs[19] = mk(B+4,      1, 4'h2, 32'h0000_0300, B+4,      32'h0000_0300, 32'hFFFF_ABFF, 8'h00);
        vecs[20] = mk(B+4,      1, 4'h1, 32'h0000_0002, B+4,      32'h0000_0302, 32'hFFFF_ABFF, 8'h00);
        vecs[21] = mk(B,        0, 4'h0, 32'h0,         B+4,      32'h0000_0302, 32'hFFFF_ABFF, 8'h03);
        vecs[22] = mk(B+4,      1, 4'hF, 32'h0,         B+4,      32'h0000_0000, 32'hFFFF_ABFF, 8'h03);
        vecs[23] = mk(B,        0, 4'h0, 32'h0,         B+3,      32'hFFFF_ABFF, 32'hFFFF_ABFF, 8'h00);
        vecs[24] = mk(B+8,      1, 4'hF, 32'hFFFF_FFFF, B+8,      32'h0004_0000, 32'hFFFF_ABFF, 8'h00);

        // Reset state
        do_reset();
        check("reset_disp", data_to_display, 32'h0);
        check("reset_mask", {24'h0, blank_mask}, 32'h0);
        read_check("reset_rd_data", B, 32'h0);
        read_check("reset_rd_ctrl", B+4, 32'h0);
        read_check("reset_rd_status", B+8, 32'h0);

        // Directed vector table
        for (int i = 0; i < 25; i++) begin
            cycle(vecs[i].addr, vecs[i].we, vecs[i].wbe, vecs[i].wdata);
            check($sformatf("vec%0d_disp", i), data_to_display, vecs[i].exp_disp);
            check($sformatf("vec%0d_mask", i), {24'h0, blank_mask}, {24'h0, vecs[i].exp_mask});
            read_check($sformatf("vec%0d_rdata", i), vecs[i].rd_addr, vecs[i].exp_rd);
        end

        // Blink on digits 0-3: phase toggles every DIV edges, mask lags by one
        cycle(B+4, 1'b1, 4'hF, 32'h0000_0F01);
        check("blink_en_mask", {24'h0, blank_mask}, 32'h0);
        read_check("blink_en_status", B+8, 32'h0004_0000);
        for (int k = 1; k <= 11; k++) begin
            idle();
            check($sformatf("blink_k%0d_mask", k), {24'h0, blank_mask},
                  (((k - 1) / 4) % 2 == 1) ? 32'h0000_000F : 32'h0);
            read_check($sformatf("blink_k%0d_status", k), B+8,
                       32'h0004_0000 | 32'((k / 4) % 2));
        end
        // Edge 12 is a 0->1 terminal-count edge; the clear must win
        cycle(B+4, 1'b1, 4'hF, 32'h0);
        read_check("blink_clear_status", B+8, 32'h0004_0000);
        read_check("blink_clear_ctrl", B+4, 32'h0);
        idle();
        check("blink_clear_mask", {24'h0, blank_mask}, 32'h0);
        read_check("blink_clear_status2", B+8, 32'h0004_0000);

        // Asynchronous reset mid-blink with freeze set
        cycle(B, 1'b1, 4'hF, 32'hA5A5_5A5A);
        cycle(B+4, 1'b1, 4'hF, 32'h0000_FF05);
        repeat (6) idle();
        check("pre_rst_mask", {24'h0, blank_mask}, 32'h0000_00FF);
        check("pre_rst_disp", data_to_display, 32'hA5A5_5A5A);
        rst_n = 1'b0;
        #1;
        check("async_rst_disp", data_to_display, 32'h0);
        check("async_rst_mask", {24'h0, blank_mask}, 32'h0);
        read_check("async_rst_rd_data", B, 32'h0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        read_check("post_rst_ctrl", B+4, 32'h0);
        read_check("post_rst_status", B+8, 32'h0);
        cycle(B+4, 1'b1, 4'h1, 32'h0000_0001);
        for (int k = 1; k <= DIV; k++) begin
            idle();
            read_check($sformatf("restart_k%0d_phase", k), B+8, (k >= DIV) ? 32'h1 : 32'h0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a, ra;
            int unsigned pick;
            pick = $urandom_range(0, 5);
            if (pick < 4)       a = B + 32'(pick * 4) + 32'($urandom_range(0, 3));
            else if (pick == 4) a = B + 32'h10 + 32'($urandom_range(0, 15));
            else                a = $urandom;
            cycle(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
            check("rand_disp", data_to_display, m_shadow);
            check("rand_mask", {24'h0, blank_mask}, {24'h0, m_mask});
            ra = B + 32'($urandom_range(0, 15));
            read_check("rand_rdata", ra, m_read(ra));
        end

        // wr_count wrap after 65536 counted DATA writes
        do_reset();
        for (int n = 0; n < 65535; n++) begin
            cycle(B, 1'b1, 4'($urandom_range(1, 15)), 32'(n));
        end
        read_check("wrap_ffff", B+8, 32'hFFFF_0000);
        cycle(B, 1'b1, 4'h1, 32'h0);
        read_check("wrap_zero", B+8, 32'h0000_0000);
        cycle(B, 1'b1, 4'h8, 32'h0);
        read_check("wrap_one", B+8, 32'h0001_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
